// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A programmable divider turns the system clock into a pixel tick, the
// h/v counters advance on each tick, and a registered output stage turns
// the counter state into mutually aligned sync, data-enable, coordinates
// and line/frame markers.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame
// counter output (o_frame_cnt).
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int CNT_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_run,
  output logic             o_pix_stb,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Region boundaries are one bit wider so a boundary equal to 2^CNT_W
  // (total exactly filling the counter) still compares correctly.
  localparam logic [CNT_W:0] H_VIS_END  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] H_SYNC_BEG = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_VIS_END  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] V_SYNC_BEG = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  // IDLE: raster parked at origin, waiting for the first tick.
  // RUN:  first pixel issued; later ticks advance the counters.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_tick_d;
  logic             r_pix_stb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_active;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_h_zero;
  logic             w_v_zero;
  logic [CNT_W:0]   w_h_ext;
  logic [CNT_W:0]   w_v_ext;
  logic             w_de;
  logic             w_hs_on;
  logic             w_vs_on;

  assign w_tick   = i_run && (r_div == DIV_LAST);
  assign w_active = (r_state == ST_RUN);
  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_h_zero = (r_h == '0);
  assign w_v_zero = (r_v == '0);
  assign w_h_ext  = {1'b0, r_h};
  assign w_v_ext  = {1'b0, r_v};
  assign w_de     = (w_h_ext < H_VIS_END) && (w_v_ext < V_VIS_END);
  assign w_hs_on  = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
  assign w_vs_on  = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);

  // State register for the idle/run controller.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The first tick after start issues pixel (0,0) without advancing;
  // dropping run parks the controller immediately.
  always_comb begin
    w_state_next = r_state;
    if (!i_run) begin
      w_state_next = ST_IDLE;
    end else if ((r_state == ST_IDLE) && w_tick) begin
      w_state_next = ST_RUN;
    end
  end

  // Pixel divider and h/v raster counters; run low clears them at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!i_run) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_tick && w_active) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : (r_v + CNT_W'(1));
        end else begin
          r_h <= r_h + CNT_W'(1);
        end
      end
    end
  end

  // Output stage: registers the decoded counter state so every output
  // changes on the same clock, with the strobe delayed to line up.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tick_d      <= 1'b0;
      r_pix_stb     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_tick_d  <= w_tick;
      r_pix_stb <= r_tick_d;
      if (w_active) begin
        r_x           <= r_h;
        r_y           <= r_v;
        r_de          <= w_de;
        r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
        r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
        r_line_start  <= r_tick_d && w_h_zero;
        r_frame_start <= r_tick_d && w_h_zero && w_v_zero;
      end else begin
        r_x           <= '0;
        r_y           <= '0;
        r_de          <= 1'b0;
        r_hsync       <= ~HS_POL;
        r_vsync       <= ~VS_POL;
        r_line_start  <= 1'b0;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign o_pix_stb     = r_pix_stb;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame;
  logic [15:0] r_frame_out;

  // Counts completed frames; bumps on the tick that wraps back to (0,0).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame <= '0;
    end else if (!i_run) begin
      r_frame <= '0;
    end else if (w_tick && w_active && w_h_last && w_v_last) begin
      r_frame <= r_frame + 16'd1;
    end
  end

  // Frame count is registered alongside the other outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame_out <= '0;
    end else begin
      r_frame_out <= w_active ? r_frame : 16'd0;
    end
  end

  assign o_frame_cnt = r_frame_out;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator. It is the next generation of the team's fixed 640x480 H/V sync block.
- Derives a pixel strobe from the system clock with a programmable integer divider.
- Runs horizontal and vertical counters and produces registered, mutually aligned hsync, vsync, data-enable, coordinates and frame/line markers.
- Sits between the system clock domain and the pixel/colour pipeline that drives the DAC.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
VS_POL, 0, vsync active level
CLK_DIV, 2, system clocks per pixel (>=1)
CNT_W, 10, coordinate width; H_TOTAL and V_TOTAL must both be <= 2^CNT_W

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = generate timing; 0 = hold the raster at origin
pix_stb  out  1  one-clk pulse marking the first clk of each new pixel on the outputs
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
de  out  1  1 while the pixel is in the visible area
x  out  CNT_W  horizontal count, 0..H_TOTAL-1
y  out  CNT_W  vertical count, 0..V_TOTAL-1
line_start  out  1  one-clk pulse on pix_stb when x==0
frame_start  out  1  one-clk pulse on pix_stb when x==0 and y==0

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
- Line and frame region order: visible, front porch, sync, back porch.
- Reset (reset_n=0, asynchronous), all outputs and internal state:
  - div counter 0, h_cnt 0, v_cnt 0.
  - x=0, y=0, de=0, pix_stb=0, line_start=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL (inactive).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while run=1.
  - tick is high when div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives tick every clk.
- Counters advance only on tick:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and wraps V_TOTAL-1 -> 0.
  - Both wraps on the same tick at the end of a frame: next state is (0,0).
- Output stage: every output is registered from the counter state, giving 1 clk latency after a counter update. x, y, de, hsync and vsync are therefore always mutually consistent.
- pix_stb is tick delayed two registers, so it aligns with the first clk in which new x/y are visible.
- Decodes, all evaluated on the registered counters:
  - de = (h<H_VISIBLE) && (v<V_VISIBLE).
  - hsync is active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync is active for V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC. It changes on the same pixel as h wraps to 0.
- First pixel: frame_start and line_start both pulse on the first pix_stb showing (0,0), including the first pixel after reset or after run rises.
- run=0 (synchronous):
  - At the next clk edge, div_cnt, h_cnt and v_cnt clear to 0.
  - Outputs go to their reset values one clk later and hold there.
  - run falling mid-line or mid-frame aborts immediately; no partial-line completion.
- run rising: the first tick occurs CLK_DIV clks later. Counting restarts from (0,0), and the first pix_stb/frame_start follows after the output latency.
- Coordinate arithmetic is unsigned CNT_W bits and never exceeds the total minus 1.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds output port frame_cnt (16 bits).
  - Resets to 0.
  - Increments by 1 coincident with each frame_start after the first one following reset or run rising.
  - Wraps 0xFFFF -> 0.
  - Cleared by run=0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults (CLK_DIV=2), run=1 from reset:
   - pix_stb period = 2 clk.
   - line_start period = 1600 clk.
   - frame_start period = 840000 clk.
   - x cycles 0..799; y cycles 0..524.
2. Defaults, one full frame:
   - de high on exactly 307200 pix_stb cycles.
   - hsync low exactly for x=656..751.
   - vsync low exactly for y=490..491.
   - No glitch between pix_stb pulses.
3. CLK_DIV=1, HS_POL=1, VS_POL=1, H=8/2/3/3, V=4/1/1/2:
   - H_TOTAL=16, V_TOTAL=8.
   - hsync high for x=10..12; vsync high for y=5.
   - frame_start every 128 clk.
4. Drop run to 0 at x=300, y=200:
   - After 2 clk: x=0, y=0, de=0, syncs inactive.
   - Raise run: first frame_start with (0,0) appears after CLK_DIV plus the output latency.
5. Assert reset_n low asynchronously mid-line:
   - Outputs go to reset values without a clock edge.
   - After release, behaviour matches scenario 1 from (0,0).
6. With VGA_TIMING_FRAME_CNT_EN, CLK_DIV=1, small geometry from scenario 3:
   - frame_cnt reads 0,1,2,3 on successive frame_start pulses.
   - Returns to 0 after run toggles.
